// File: rtl/bp_pkg.sv
// Shared types and constants for the fetch-stage branch predictor.
// The 2-bit counter encoding is ordered so that bit 1 is the taken prediction.
package bp_pkg;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t BHT_SNT   = 2'b00;
  localparam bht_ctr_t BHT_WNT   = 2'b01;
  localparam bht_ctr_t BHT_WT    = 2'b10;
  localparam bht_ctr_t BHT_ST    = 2'b11;
  localparam bht_ctr_t BHT_RESET = BHT_WNT;

  // op_ex[6:4] value that marks a control-flow instruction in EX
  localparam logic [2:0] OP_BRANCH_GRP = 3'b110;

endpackage

// File: rtl/fetch_pc_predictor_sat_counter2.sv
// Next-state function of one 2-bit saturating branch history counter.
// Pure combinational; the table register lives in the top level.
module sat_counter2
  import bp_pkg::*;
(
  input  bht_ctr_t i_ctr,
  input  logic     i_taken,
  output bht_ctr_t o_ctr
);

  always_comb begin
    o_ctr = i_ctr;
    case (i_ctr)
      BHT_SNT: o_ctr = i_taken ? BHT_WNT : BHT_SNT;
      BHT_WNT: o_ctr = i_taken ? BHT_WT  : BHT_SNT;
      BHT_WT:  o_ctr = i_taken ? BHT_ST  : BHT_WNT;
      BHT_ST:  o_ctr = i_taken ? BHT_ST  : BHT_WT;
      default: o_ctr = BHT_RESET;
    endcase
  end

endmodule

// File: rtl/fetch_pc_predictor.sv
// IF-stage PC generator with a BHT of 2-bit counters and a direct-mapped BTB.
// Lookup is combinational on the fetch PC; training is written at the clock edge (read-old).
module fetch_pc_predictor
  import bp_pkg::*;
#(
  parameter int          ENTRIES  = 64,
  parameter int          IDX_W    = $clog2(ENTRIES),
  parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_pc,
  input  logic        comp_i,
  input  logic [31:0] pc_jump_ex_i,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i,
  output logic [31:0] pc_if_o,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o
);

  localparam int TAG_W = 32 - IDX_W - 2;

  logic [31:0]       r_pc;
  bht_ctr_t          r_bht       [ENTRIES];
  logic [ENTRIES-1:0] r_btbValid;
  logic [TAG_W-1:0]  r_btbTag    [ENTRIES];
  logic [31:0]       r_btbTarget [ENTRIES];

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_hit;
  logic [31:0]       w_pcPlus4;
  logic [IDX_W-1:0]  w_updIdx;
  logic [TAG_W-1:0]  w_updTag;
  bht_ctr_t          w_updCtr;
  logic              w_unused;

  assign w_idx     = r_pc[IDX_W+1:2];
  assign w_tag     = r_pc[31:IDX_W+2];
  assign w_pcPlus4 = r_pc + 32'd4;
  assign w_updIdx  = upd_pc_i[IDX_W+1:2];
  assign w_updTag  = upd_pc_i[31:IDX_W+2];
  assign w_unused  = &{1'b0, upd_pc_i[1:0]};

  assign w_hit         = r_btbValid[w_idx] && (r_btbTag[w_idx] == w_tag);
  assign pred_taken_o  = w_hit && r_bht[w_idx][1];
  assign pred_target_o = pred_taken_o ? r_btbTarget[w_idx] : w_pcPlus4;
  assign pc_if_o       = r_pc;

  sat_counter2 u_satCounter (
    .i_ctr   (r_bht[w_updIdx]),
    .i_taken (upd_taken_i),
    .o_ctr   (w_updCtr)
  );

  // A mispredict redirect wins over a stall request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (comp_i) begin
      r_pc <= pc_jump_ex_i;
    end else if (!stall_pc) begin
      r_pc <= pred_target_o;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_bht[i] <= BHT_RESET;
      end
      r_btbValid <= '0;
    end else if (upd_valid_i) begin
      r_bht[w_updIdx] <= w_updCtr;
      if (upd_taken_i) begin
        r_btbValid[w_updIdx] <= 1'b1;
      end
    end
  end

  // Tag and target are meaningless until the valid bit is set, so they carry no reset
  always_ff @(posedge clk) begin
    if (upd_valid_i && upd_taken_i) begin
      r_btbTag[w_updIdx]    <= w_updTag;
      r_btbTarget[w_updIdx] <= upd_target_i;
    end
  end

endmodule

// File: tb/tb_fetch_pc_predictor.sv
// Self-checking bench for fetch_pc_predictor: directed scenarios plus a randomized run
// compared against an array-based reference model of the BHT/BTB and fetch PC.
module tb_fetch_pc_predictor;
  import bp_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_pc;
  logic        comp_i;
  logic [31:0] pc_jump_ex_i;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;
  logic [31:0] pc_if_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          mCtr    [64];
  bit          mValid  [64];
  logic [31:0] mTag    [64];
  logic [31:0] mTarget [64];
  logic [31:0] mPc;

  fetch_pc_predictor dut (
    .clk           (clk),
    .rst           (rst),
    .stall_pc      (stall_pc),
    .comp_i        (comp_i),
    .pc_jump_ex_i  (pc_jump_ex_i),
    .upd_valid_i   (upd_valid_i),
    .upd_pc_i      (upd_pc_i),
    .upd_taken_i   (upd_taken_i),
    .upd_target_i  (upd_target_i),
    .pc_if_o       (pc_if_o),
    .pred_taken_o  (pred_taken_o),
    .pred_target_o (pred_target_o)
  );

  always #5 clk = ~clk;

  function automatic int mIdx(logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic bit mPredTaken(logic [31:0] pc);
    int i;
    i = mIdx(pc);
    return mValid[i] && (mTag[i] == (pc >> 8)) && (mCtr[i] >= 2);
  endfunction

  function automatic logic [31:0] mPredTarget(logic [31:0] pc);
    if (mPredTaken(pc)) return mTarget[mIdx(pc)];
    return pc + 32'd4;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 64; i++) begin
      mCtr[i]   = 1;
      mValid[i] = 1'b0;
    end
    mPc = 32'h0;
  endtask

  task automatic idleInputs();
    stall_pc     = 1'b0;
    comp_i       = 1'b0;
    pc_jump_ex_i = 32'h0;
    upd_valid_i  = 1'b0;
    upd_pc_i     = 32'h0;
    upd_taken_i  = 1'b0;
    upd_target_i = 32'h0;
  endtask

  // One clock: the model applies the same edge using pre-edge table contents
  task automatic tick();
    logic [31:0] nextPc;
    int u;
    @(posedge clk);
    if (comp_i)        nextPc = pc_jump_ex_i;
    else if (stall_pc) nextPc = mPc;
    else               nextPc = mPredTarget(mPc);
    if (upd_valid_i) begin
      u = mIdx(upd_pc_i);
      if (upd_taken_i) begin
        mCtr[u]    = (mCtr[u] == 3) ? 3 : mCtr[u] + 1;
        mValid[u]  = 1'b1;
        mTag[u]    = upd_pc_i >> 8;
        mTarget[u] = upd_target_i;
      end else begin
        mCtr[u] = (mCtr[u] == 0) ? 0 : mCtr[u] - 1;
      end
    end
    mPc = nextPc;
    #1;
  endtask

  task automatic test_reset();
    idleInputs();
    rst = 1'b1;
    modelReset();
    #12;
    checks++;
    if (pc_if_o !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_pc actual=%h expected=%h", pc_if_o, 32'h0);
    end
    checks++;
    if (pred_taken_o !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_pred_taken actual=%b expected=0", pred_taken_o);
    end
    checks++;
    if (pred_target_o !== 32'h4) begin
      errors++; $display("[TB] FAIL reset_pred_target actual=%h expected=%h", pred_target_o, 32'h4);
    end
    rst = 1'b0;
  endtask

  task automatic test_free_run();
    logic [31:0] expPc;
    for (int i = 0; i < 4; i++) begin
      expPc = 32'(i * 4);
      checks++;
      if (pc_if_o !== expPc || pred_taken_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL free_run cycle=%0d actual pc=%h taken=%b expected pc=%h taken=0",
                 i, pc_if_o, pred_taken_o, expPc);
      end
      tick();
    end
  endtask

  task automatic test_train();
    int budget;
    upd_valid_i = 1'b1; upd_pc_i = 32'h40; upd_taken_i = 1'b1; upd_target_i = 32'h100;
    tick();
    idleInputs();
    budget = 0;
    while (pc_if_o !== 32'h40 && budget < 64) begin
      tick();
      budget++;
    end
    checks++;
    if (pc_if_o !== 32'h40) begin
      errors++; $display("[TB] FAIL train_reach_pc actual=%h expected=%h", pc_if_o, 32'h40);
    end
    checks++;
    if (pred_taken_o !== 1'b1 || pred_target_o !== 32'h100) begin
      errors++;
      $display("[TB] FAIL train_predict actual taken=%b target=%h expected taken=1 target=%h",
               pred_taken_o, pred_target_o, 32'h100);
    end
    tick();
    checks++;
    if (pc_if_o !== 32'h100) begin
      errors++; $display("[TB] FAIL train_follow actual=%h expected=%h", pc_if_o, 32'h100);
    end
  endtask

  task automatic test_saturation();
    stall_pc = 1'b1;
    upd_valid_i = 1'b1; upd_pc_i = 32'h40; upd_target_i = 32'h100;
    upd_taken_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    upd_taken_i = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    upd_valid_i = 1'b0;
    comp_i = 1'b1; pc_jump_ex_i = 32'h40;
    tick();
    comp_i = 1'b0;
    checks++;
    if (pc_if_o !== 32'h40 || pred_taken_o !== 1'b0 || pred_target_o !== 32'h44) begin
      errors++;
      $display("[TB] FAIL sat_floor actual pc=%h taken=%b target=%h expected pc=%h taken=0 target=%h",
               pc_if_o, pred_taken_o, pred_target_o, 32'h40, 32'h44);
    end
    stall_pc = 1'b0;
    tick();
    checks++;
    if (pc_if_o !== 32'h44) begin
      errors++; $display("[TB] FAIL sat_next_pc actual=%h expected=%h", pc_if_o, 32'h44);
    end
    // A floor counter needs two taken steps before predicting taken
    upd_valid_i = 1'b1; upd_taken_i = 1'b1;
    comp_i = 1'b1; pc_jump_ex_i = 32'h40;
    tick();
    idleInputs();
    stall_pc = 1'b1;
    checks++;
    if (pred_taken_o !== 1'b0 || pred_taken_o !== mPredTaken(mPc)) begin
      errors++; $display("[TB] FAIL sat_one_step actual=%b expected=0", pred_taken_o);
    end
    stall_pc = 1'b0;
  endtask

  task automatic test_alias();
    upd_valid_i = 1'b1; upd_pc_i = 32'h40; upd_taken_i = 1'b1; upd_target_i = 32'h100;
    comp_i = 1'b1; pc_jump_ex_i = 32'h140;
    tick();
    idleInputs();
    stall_pc = 1'b1;
    checks++;
    if (pc_if_o !== 32'h140 || pred_taken_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL alias_no_hit actual pc=%h taken=%b expected pc=%h taken=0",
               pc_if_o, pred_taken_o, 32'h140);
    end
    upd_valid_i = 1'b1; upd_pc_i = 32'h140; upd_taken_i = 1'b1; upd_target_i = 32'h300;
    #1;
    checks++;
    if (pred_taken_o !== 1'b0) begin
      errors++; $display("[TB] FAIL alias_read_old actual=%b expected=0", pred_taken_o);
    end
    tick();
    upd_valid_i = 1'b0;
    checks++;
    if (pred_taken_o !== 1'b1 || pred_target_o !== 32'h300) begin
      errors++;
      $display("[TB] FAIL alias_evict_hit actual taken=%b target=%h expected taken=1 target=%h",
               pred_taken_o, pred_target_o, 32'h300);
    end
    stall_pc = 1'b0;
    tick();
    checks++;
    if (pc_if_o !== 32'h300) begin
      errors++; $display("[TB] FAIL alias_follow actual=%h expected=%h", pc_if_o, 32'h300);
    end
    comp_i = 1'b1; pc_jump_ex_i = 32'h40;
    tick();
    comp_i = 1'b0;
    checks++;
    if (pc_if_o !== 32'h40 || pred_taken_o !== 1'b0 || pred_target_o !== 32'h44) begin
      errors++;
      $display("[TB] FAIL alias_old_evicted actual pc=%h taken=%b target=%h expected pc=%h taken=0 target=%h",
               pc_if_o, pred_taken_o, pred_target_o, 32'h40, 32'h44);
    end
  endtask

  task automatic test_priority();
    stall_pc = 1'b1; comp_i = 1'b1; pc_jump_ex_i = 32'h200;
    tick();
    comp_i = 1'b0;
    checks++;
    if (pc_if_o !== 32'h200) begin
      errors++; $display("[TB] FAIL prio_comp_over_stall actual=%h expected=%h", pc_if_o, 32'h200);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (pc_if_o !== 32'h200) begin
        errors++; $display("[TB] FAIL prio_stall_hold cycle=%0d actual=%h expected=%h", i, pc_if_o, 32'h200);
      end
    end
    stall_pc = 1'b0;
  endtask

  task automatic test_wrap();
    comp_i = 1'b1; pc_jump_ex_i = 32'hFFFF_FFFC;
    tick();
    comp_i = 1'b0;
    checks++;
    if (pred_target_o !== 32'h0) begin
      errors++; $display("[TB] FAIL wrap_target actual=%h expected=%h", pred_target_o, 32'h0);
    end
    tick();
    checks++;
    if (pc_if_o !== 32'h0) begin
      errors++; $display("[TB] FAIL wrap_pc actual=%h expected=%h", pc_if_o, 32'h0);
    end
  endtask

  task automatic test_random();
    logic [6:0] opEx;
    for (int n = 0; n < 400; n++) begin
      stall_pc     = ($urandom_range(0, 7) == 0);
      comp_i       = ($urandom_range(0, 9) == 0);
      pc_jump_ex_i = 32'($urandom_range(0, 255)) << 2;
      opEx         = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 1) == 1) opEx[6:4] = OP_BRANCH_GRP;
      upd_valid_i  = (opEx[6:4] == OP_BRANCH_GRP);
      upd_pc_i     = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(0, 3));
      upd_taken_i  = 1'($urandom_range(0, 1));
      upd_target_i = 32'($urandom_range(0, 255)) << 2;
      #1;
      checks++;
      if (pc_if_o !== mPc || pred_taken_o !== mPredTaken(mPc) || pred_target_o !== mPredTarget(mPc)) begin
        errors++;
        $display("[TB] FAIL random cycle=%0d actual pc=%h taken=%b target=%h expected pc=%h taken=%b target=%h",
                 n, pc_if_o, pred_taken_o, pred_target_o, mPc, mPredTaken(mPc), mPredTarget(mPc));
      end
      tick();
    end
    idleInputs();
  endtask

  task automatic test_async_reset();
    upd_valid_i = 1'b1; upd_pc_i = 32'h40; upd_taken_i = 1'b1; upd_target_i = 32'h100;
    stall_pc = 1'b1;
    tick();
    tick();
    idleInputs();
    comp_i = 1'b1; pc_jump_ex_i = 32'h100;
    tick();
    comp_i = 1'b0;
    checks++;
    if (pc_if_o !== 32'h100) begin
      errors++; $display("[TB] FAIL areset_setup actual=%h expected=%h", pc_if_o, 32'h100);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (pc_if_o !== 32'h0 || pred_taken_o !== 1'b0 || pred_target_o !== 32'h4) begin
      errors++;
      $display("[TB] FAIL areset_immediate actual pc=%h taken=%b target=%h expected pc=0 taken=0 target=4",
               pc_if_o, pred_taken_o, pred_target_o);
    end
    modelReset();
    #1 rst = 1'b0;
    comp_i = 1'b1; pc_jump_ex_i = 32'h40;
    tick();
    comp_i = 1'b0;
    checks++;
    if (pc_if_o !== 32'h40 || pred_taken_o !== 1'b0 || pred_target_o !== 32'h44) begin
      errors++;
      $display("[TB] FAIL areset_training_lost actual pc=%h taken=%b target=%h expected pc=%h taken=0 target=%h",
               pc_if_o, pred_taken_o, pred_target_o, 32'h40, 32'h44);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_train();
    test_saturation();
    test_alias();
    test_priority();
    test_wrap();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
